multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for the 8-bit MIPS datapath.
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset, as listed below.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces state to FETCH1 immediately.
REQ-005 op  input  6  instruction opcode field, IR[31:26], valid from DECODE onward.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 memread, memwrite  output  1 each  memory read / write strobes.
REQ-008 alusrca, iord, memtoreg, regdst, regwrite  output  1 each  datapath mux selects and register-file write enable.
REQ-009 alusrcb  output  2  4:1 ALU B-source mux select (00 reg B, 01 constant 1, 10 imm, 11 branch offset).
REQ-010 pcsrc  output  2  4:1 PC-source mux select (00 ALU result, 01 ALUOut, 10 jump target).
REQ-011 aluop  output  2  ALU decoder class (00 add, 01 sub, 10 funct).
REQ-012 irwrite  output  4  one-hot byte enable for instruction-register byte 0..3.
REQ-013 pcen  output  1  PC write enable.
REQ-014 state  output  4  current state encoding, for debug and verification.

Function
REQ-015 The controller SHALL be a Moore FSM; every output except pcen SHALL be decoded from the current state only.
REQ-016 State encoding SHALL be: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14; code 15 is unused.
REQ-017 Opcodes SHALL be: LB=100000, SB=101000, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.
REQ-018 Transitions SHALL be: FETCH1->FETCH2->FETCH3->FETCH4->DECODE, unconditional.
REQ-019 From DECODE: LB/SB->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, J->JEX, ADDI->ADDIEX; any other opcode->FETCH1 (illegal instruction is skipped, with no register or memory write).
REQ-020 From MEMADR: LB->LBRD, otherwise->SBWR; LBRD->LBWR; RTYPEEX->RTYPEWR; ADDIEX->ADDIWR.
REQ-021 LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR and state 15 SHALL all go to FETCH1.
REQ-022 Outputs SHALL be 0 by default; each state asserts only the following:
- FETCHn: memread=1, alusrcb=01, pcwrite=1, irwrite=one-hot bit n-1 (0001, 0010, 0100, 1000).
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- LBRD: memread=1, iord=1.
- LBWR: regwrite=1, memtoreg=1.
- SBWR: memwrite=1, iord=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWR: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, branch=1, pcsrc=01.
- JEX: pcwrite=1, pcsrc=10.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWR: regwrite=1.
- State 15: all outputs 0.
REQ-023 pcen SHALL equal pcwrite OR (branch AND zero), combinationally; pcwrite and branch are internal signals only.
REQ-024 Instruction latency SHALL be: LB 8 cycles; SB, RTYPE and ADDI 7; BEQ and J 6; illegal opcode 5.
REQ-025 At most one irwrite bit SHALL be set in any cycle; memread and memwrite SHALL never both be 1.

Reset
REQ-026 While reset=0, state SHALL be FETCH1 and the outputs SHALL show FETCH1 values; pcen=1 during reset is harmless because the PC is also held in reset.
REQ-027 Reset asserted in any state, mid-instruction, SHALL abort the instruction with no further writes; after reset is released, the first rising edge advances FETCH1->FETCH2.

Verification
REQ-028 Release reset, op=000000: state sequence 0,1,2,3,4,9,10,0; regwrite=1 and regdst=1 only in state 10; irwrite=0001,0010,0100,1000 in cycles 1-4.
REQ-029 op=100000: sequence 0,1,2,3,4,5,6,7,0; iord=1 in state 6; memtoreg=1 and regwrite=1 in state 7; memwrite never 1.
REQ-030 op=000100 with zero=1 in BEQEX: pcen=1 and pcsrc=01. Repeat with zero=0: pcen=0 in BEQEX, next state 0.
REQ-031 op=111111: sequence 0,1,2,3,4,0; regwrite and memwrite stay 0 throughout.
REQ-032 op=101000, reset=0 pulsed asynchronously mid-cycle in state 5: state is 0 immediately, memwrite never asserted, and the fetch restarts after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
//==============================================================================
// Module      : multicycle_ctrl
// Description : Moore FSM controller for the 8-bit multicycle MIPS datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] irwrite,
    output logic       pcen,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
        S_UNUSED  = 4'd15
    } state_t;

    localparam logic [5:0] C_OP_LB    = 6'b100000;
    localparam logic [5:0] C_OP_SB    = 6'b101000;
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;

    state_t r_state;
    state_t w_next;
    logic   w_pcwrite;
    logic   w_branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH1;
        case (r_state)
            S_FETCH1: w_next = S_FETCH2;
            S_FETCH2: w_next = S_FETCH3;
            S_FETCH3: w_next = S_FETCH4;
            S_FETCH4: w_next = S_DECODE;
            S_DECODE: begin
                // Unknown opcodes fall back to fetch so nothing gets written.
                case (op)
                    C_OP_LB,
                    C_OP_SB:    w_next = S_MEMADR;
                    C_OP_RTYPE: w_next = S_RTYPEEX;
                    C_OP_BEQ:   w_next = S_BEQEX;
                    C_OP_J:     w_next = S_JEX;
                    C_OP_ADDI:  w_next = S_ADDIEX;
                    default:    w_next = S_FETCH1;
                endcase
            end
            S_MEMADR:  w_next = (op == C_OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    w_next = S_LBWR;
            S_RTYPEEX: w_next = S_RTYPEWR;
            S_ADDIEX:  w_next = S_ADDIWR;
            default:   w_next = S_FETCH1;
        endcase
    end

    always_comb begin
        memread   = 1'b0;
        memwrite  = 1'b0;
        alusrca   = 1'b0;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        regwrite  = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        aluop     = 2'b00;
        irwrite   = 4'b0000;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        case (r_state)
            S_FETCH1: begin
                memread = 1'b1; alusrcb = 2'b01; w_pcwrite = 1'b1; irwrite = 4'b0001;
            end
            S_FETCH2: begin
                memread = 1'b1; alusrcb = 2'b01; w_pcwrite = 1'b1; irwrite = 4'b0010;
            end
            S_FETCH3: begin
                memread = 1'b1; alusrcb = 2'b01; w_pcwrite = 1'b1; irwrite = 4'b0100;
            end
            S_FETCH4: begin
                memread = 1'b1; alusrcb = 2'b01; w_pcwrite = 1'b1; irwrite = 4'b1000;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_LBRD:    begin memread = 1'b1; iord = 1'b1; end
            S_LBWR:    begin regwrite = 1'b1; memtoreg = 1'b1; end
            S_SBWR:    begin memwrite = 1'b1; iord = 1'b1; end
            S_RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
            S_RTYPEWR: begin regdst = 1'b1; regwrite = 1'b1; end
            S_BEQEX: begin
                alusrca = 1'b1; aluop = 2'b01; w_branch = 1'b1; pcsrc = 2'b01;
            end
            S_JEX:     begin w_pcwrite = 1'b1; pcsrc = 2'b10; end
            S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_ADDIWR:  regwrite = 1'b1;
            default:   ;
        endcase
    end

    // The only Mealy-style term: a taken branch depends on the live zero flag.
    assign pcen  = w_pcwrite | (w_branch & zero);
    assign state = r_state;

endmodule

`default_nettype wire
